// File: rtl/tpu_commit_rob_pkg.sv
// Shared types and constants for the TPU commit/reorder-buffer slice.
//   NUM_ENTRY_ROB : default reorder-buffer depth
//   NUM_LANES_ROB : default lane count for the packed entry type
//   issue_no_t    : legacy 8-bit issue number, still used by width-8 callers
//   rob_no_t      : issue number sized for the default ROB depth
//   rob_entry_t   : one ROB slot {v, en_lane, done} at the default lane count
package tpu_commit_rob_pkg;

  localparam int NUM_ENTRY_ROB = 16;
  localparam int NUM_LANES_ROB = 16;
  localparam int ROB_NO_W      = $clog2(NUM_ENTRY_ROB);

  typedef logic [7:0]          issue_no_t;
  typedef logic [ROB_NO_W-1:0] rob_no_t;

  typedef struct packed {
    logic                     v;
    logic [NUM_LANES_ROB-1:0] en_lane;
    logic [NUM_LANES_ROB-1:0] done;
  } rob_entry_t;

endpackage

// File: rtl/tpu_rob_entry.sv
// One reorder-buffer slot.
//   clock, reset     : system clock, synchronous active-high reset
//   alloc            : write this slot {v=1, en_lane=alloc_en_lane, done=0}
//   retire           : clear this slot (it is the retiring head)
//   commit/commit_no : per-lane completion pulses and their target issue numbers
//   complete         : slot valid and every enabled lane has reported
//   err              : a report this cycle targets this slot while it is
//                      invalid or on a lane it does not enable
module tpu_rob_entry #(
  parameter int NUM_LANES = 16,
  parameter int WIDTH_NO  = 4,
  parameter int IDX       = 0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               alloc,
  input  logic [NUM_LANES-1:0]               alloc_en_lane,
  input  logic                               retire,
  input  logic [NUM_LANES-1:0]               commit,
  input  logic [NUM_LANES-1:0][WIDTH_NO-1:0] commit_no,
  output logic                               complete,
  output logic                               err
);

  typedef struct packed {
    logic                 v;
    logic [NUM_LANES-1:0] en_lane;
    logic [NUM_LANES-1:0] done;
  } entry_t;

  entry_t               ent;
  logic [NUM_LANES-1:0] hit;

  always_comb begin
    hit = '0;
    for (int l = 0; l < NUM_LANES; l++)
      hit[l] = commit[l] && (commit_no[l] == WIDTH_NO'(IDX));
  end

  // Issue numbers map one-to-one onto slots, so the top simply ORs these.
  assign err      = |(hit & ~(ent.en_lane & {NUM_LANES{ent.v}}));
  assign complete = ent.v & (&(ent.done | ~ent.en_lane));

  // alloc and retire never hit the same slot in one edge: that needs
  // head==tail with count either 0 (no retire) or full (no alloc).
  always_ff @(posedge clock) begin
    if (reset)
      ent <= '0;
    else if (retire)
      ent <= '0;
    else if (alloc)
      ent <= '{v: 1'b1, en_lane: alloc_en_lane, done: '0};
    else if (ent.v)
      ent.done <= ent.done | (hit & ent.en_lane);
  end

endmodule

// File: rtl/tpu_commit_rob.sv
// In-order commit tracker (reorder buffer).
//   clock, reset           : system clock, synchronous active-high reset
//   I_Issue, I_En_Lane     : allocate one entry with the given required lanes
//   O_Issue_No             : number the allocation receives (tail pointer)
//   O_Full/O_Empty/O_Count : occupancy, combinational from the count register
//   I_Commit, I_Commit_No  : per-lane completion reports, any order
//   O_Retire, O_Retire_No  : registered in-order retire pulse and its number
//   O_Err                  : sticky protocol error (overflow, bad commit)
module tpu_commit_rob
  import tpu_commit_rob_pkg::*;
#(
  parameter int DEPTH     = NUM_ENTRY_ROB,
  parameter int NUM_LANES = 16,
  parameter int WIDTH_NO  = $clog2(DEPTH)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               I_Issue,
  input  logic [NUM_LANES-1:0]               I_En_Lane,
  output logic [WIDTH_NO-1:0]                O_Issue_No,
  output logic                               O_Full,
  output logic                               O_Empty,
  output logic [$clog2(DEPTH+1)-1:0]         O_Count,
  input  logic [NUM_LANES-1:0]               I_Commit,
  input  logic [NUM_LANES-1:0][WIDTH_NO-1:0] I_Commit_No,
  output logic                               O_Retire,
  output logic [WIDTH_NO-1:0]                O_Retire_No,
  output logic                               O_Err
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH_NO-1:0] head, tail;
  logic [CW-1:0]       count;
  logic [DEPTH-1:0]    ent_cmp, ent_err;
  logic                accept, retire, overflow;

  assign O_Full     = (count == CW'(DEPTH));
  assign O_Empty    = (count == '0);
  assign O_Count    = count;
  assign O_Issue_No = tail;

  // Full is judged on the pre-edge count, so a same-edge retire never
  // makes room for an allocation.
  assign accept   = I_Issue & ~O_Full;
  assign overflow = I_Issue &  O_Full;
  assign retire   = ent_cmp[head];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    tpu_rob_entry #(
      .NUM_LANES (NUM_LANES),
      .WIDTH_NO  (WIDTH_NO),
      .IDX       (g)
    ) u_ent (
      .clock         (clock),
      .reset         (reset),
      .alloc         (accept && (tail == WIDTH_NO'(g))),
      .alloc_en_lane (I_En_Lane),
      .retire        (retire && (head == WIDTH_NO'(g))),
      .commit        (I_Commit),
      .commit_no     (I_Commit_No),
      .complete      (ent_cmp[g]),
      .err           (ent_err[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      O_Retire    <= 1'b0;
      O_Retire_No <= '0;
      O_Err       <= 1'b0;
    end else begin
      if (accept) tail <= tail + WIDTH_NO'(1);
      if (retire) begin
        head        <= head + WIDTH_NO'(1);
        O_Retire_No <= head;
      end
      O_Retire <= retire;
      case ({accept, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (overflow || (|ent_err)) O_Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tpu_commit_rob.sv
// Randomised + directed bench for tpu_commit_rob against an in-order queue model.
module tb_tpu_commit_rob;

  localparam int DEPTH = 16;
  localparam int NL    = 16;
  localparam int WN    = 4;
  localparam int CW    = 5;

  typedef logic [NL-1:0][WN-1:0] cno_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              I_Issue = 1'b0;
  logic [NL-1:0]     I_En_Lane = '0;
  logic [WN-1:0]     O_Issue_No;
  logic              O_Full, O_Empty;
  logic [CW-1:0]     O_Count;
  logic [NL-1:0]     I_Commit = '0;
  cno_t              I_Commit_No = '0;
  logic              O_Retire;
  logic [WN-1:0]     O_Retire_No;
  logic              O_Err;

  tpu_commit_rob #(.DEPTH(DEPTH), .NUM_LANES(NL), .WIDTH_NO(WN)) dut (
    .clock(clock), .reset(reset), .I_Issue(I_Issue), .I_En_Lane(I_En_Lane),
    .O_Issue_No(O_Issue_No), .O_Full(O_Full), .O_Empty(O_Empty), .O_Count(O_Count),
    .I_Commit(I_Commit), .I_Commit_No(I_Commit_No), .O_Retire(O_Retire),
    .O_Retire_No(O_Retire_No), .O_Err(O_Err)
  );

  always #5 clock = ~clock;

  // Reference model: outstanding instructions in issue order.
  typedef struct {
    int            no;
    logic [NL-1:0] en;
    logic [NL-1:0] done;
  } ment_t;

  ment_t mq[$];
  int    m_tail, m_ret_no;
  bit    m_err, m_ret;
  int    n_tests, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cno_t mk_cno(input int n);
    cno_t c;
    for (int l = 0; l < NL; l++) c[l] = WN'(n);
    return c;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_tail = 0; m_ret_no = 0; m_err = 0; m_ret = 0;
  endfunction

  function automatic void model_edge(input bit iss, input logic [NL-1:0] en,
                                     input logic [NL-1:0] cm, input cno_t cno);
    bit head_done;
    bit full;
    full      = (mq.size() == DEPTH);
    head_done = (mq.size() > 0) && ((mq[0].done | ~mq[0].en) == '1);
    for (int l = 0; l < NL; l++) begin
      if (cm[l]) begin
        int k;
        k = -1;
        for (int i = 0; i < mq.size(); i++) if (mq[i].no == int'(cno[l])) k = i;
        if (k < 0 || !mq[k].en[l]) m_err = 1;
        else begin
          ment_t e;
          e = mq[k]; e.done[l] = 1'b1; mq[k] = e;
        end
      end
    end
    m_ret = head_done;
    if (head_done) begin
      m_ret_no = mq[0].no;
      void'(mq.pop_front());
    end
    if (iss) begin
      if (full) m_err = 1;
      else begin
        ment_t e;
        e.no = m_tail; e.en = en; e.done = '0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endfunction

  task automatic chk_all();
    chk("count",     O_Count,     mq.size());
    chk("empty",     O_Empty,     mq.size() == 0);
    chk("full",      O_Full,      mq.size() == DEPTH);
    chk("issue_no",  O_Issue_No,  m_tail);
    chk("retire",    O_Retire,    m_ret);
    chk("retire_no", O_Retire_No, m_ret_no);
    chk("err",       O_Err,       m_err);
  endtask

  task automatic step(input bit iss, input logic [NL-1:0] en,
                      input logic [NL-1:0] cm, input cno_t cno);
    I_Issue = iss; I_En_Lane = en; I_Commit = cm; I_Commit_No = cno;
    @(posedge clock);
    model_edge(iss, en, cm, cno);
    @(negedge clock);
    I_Issue = 1'b0; I_Commit = '0;
    chk_all();
  endtask

  // Reset with arbitrary traffic on the inputs; all of it must be dropped.
  task automatic do_reset(input bit iss, input logic [NL-1:0] cm);
    reset = 1'b1; I_Issue = iss; I_En_Lane = '1; I_Commit = cm; I_Commit_No = '0;
    @(posedge clock);
    model_reset();
    @(negedge clock);
    reset = 1'b0; I_Issue = 1'b0; I_Commit = '0;
    chk_all();
  endtask

  task automatic rnd_step();
    bit            iss;
    logic [NL-1:0] en, cm;
    cno_t          cno;
    iss = ($urandom_range(0, 99) < 55) && (mq.size() < DEPTH || $urandom_range(0, 99) < 3);
    en  = ($urandom_range(0, 3) == 0) ? '0 : NL'($urandom & $urandom);
    cm  = '0; cno = '0;
    for (int l = 0; l < NL; l++) begin
      if (mq.size() > 0 && $urandom_range(0, 99) < 35) begin
        int k;
        k = $urandom_range(0, mq.size() - 1);
        if (mq[k].en[l] || $urandom_range(0, 99) < 2) begin
          cm[l] = 1'b1; cno[l] = WN'(mq[k].no);
        end
      end else if ($urandom_range(0, 999) < 3) begin
        cm[l] = 1'b1; cno[l] = WN'($urandom);
      end
    end
    step(iss, en, cm, cno);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    model_reset();
    @(negedge clock);
    do_reset(1'b1, '1);

    // Fill to full, then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_no", O_Issue_No, i);
      step(1'b1, 16'hFFFF, '0, '0);
    end
    chk("fill_full", O_Full, 1);
    step(1'b1, 16'hFFFF, '0, '0);
    chk("ovf_err", O_Err, 1);
    chk("ovf_count", O_Count, 16);

    // Out-of-order completion, in-order retire.
    do_reset(1'b0, '0);
    step(1'b1, 16'h0003, '0, '0);
    step(1'b1, 16'h0003, '0, '0);
    step(1'b0, '0, 16'h0003, mk_cno(1));
    step(1'b0, '0, '0, '0);
    chk("young_wait", O_Retire, 0);
    step(1'b0, '0, 16'h0003, mk_cno(0));
    chk("lat_e", O_Retire, 0);
    step(1'b0, '0, '0, '0);
    chk("ret0", O_Retire, 1);
    chk("ret0_no", O_Retire_No, 0);
    step(1'b0, '0, '0, '0);
    chk("ret1", O_Retire, 1);
    chk("ret1_no", O_Retire_No, 1);

    // en_lane=0 retires the edge after allocation.
    do_reset(1'b0, '0);
    step(1'b1, '0, '0, '0);
    chk("z_noret", O_Retire, 0);
    step(1'b0, '0, '0, '0);
    chk("z_ret", O_Retire, 1);
    chk("z_ret_no", O_Retire_No, 0);

    // Full with complete head plus issue.
    do_reset(1'b0, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h0001, '0, '0);
    step(1'b0, '0, 16'h0001, mk_cno(0));
    step(1'b1, 16'h0001, '0, '0);
    chk("fr_ret", O_Retire, 1);
    chk("fr_err", O_Err, 1);
    chk("fr_count", O_Count, 15);

    // Bad commits and duplicate commit.
    do_reset(1'b0, '0);
    step(1'b0, '0, 16'h0001, mk_cno(3));
    chk("inv_err", O_Err, 1);
    do_reset(1'b0, '0);
    step(1'b1, 16'h0001, '0, '0);
    step(1'b0, '0, 16'h0002, mk_cno(0));
    chk("lane_err", O_Err, 1);
    chk("lane_count", O_Count, 1);
    do_reset(1'b0, '0);
    step(1'b1, 16'h0003, '0, '0);
    step(1'b0, '0, 16'h0001, mk_cno(0));
    step(1'b0, '0, 16'h0001, mk_cno(0));
    chk("dup_err", O_Err, 0);

    // Reset with pending entries, then wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 16'hFFFF, '0, '0);
    do_reset(1'b1, 16'hFFFF);
    chk("rst_empty", O_Empty, 1);
    chk("rst_count", O_Count, 0);
    chk("rst_ret", O_Retire, 0);
    for (int i = 0; i < 40; i++) step(1'b1, '0, '0, '0);
    step(1'b0, '0, '0, '0);

    // Random traffic with occasional resets.
    do_reset(1'b0, '0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(0, 1) == 1, NL'($urandom));
      else rnd_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
